// File: rtl/ifetch_prefetch_buf_if.sv
// Pipelined instruction-memory port: request/grant address phase, in-order response phase.
// The fetch unit drives the master side; the memory drives the slave side.
interface ifetch_prefetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/ifetch_prefetch_buf.sv
// Instruction prefetch buffer: issues sequential fetches under a credit limit, tags responses
// with their PC in a small FIFO, and drops stale responses after a redirect.
module ifetch_prefetch_buf #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [ADDR_W-1:0]     flush_addr_i,
    input  logic                  inst_ready_i,
    output logic                  inst_valid_o,
    output logic [DATA_W-1:0]     inst_o,
    output logic [ADDR_W-1:0]     inst_addr_o,
    ifetch_prefetch_buf_if.master mem
);
    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(DATA_W / 8);
    localparam logic [CNT_W:0]    CREDIT = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
    logic [CNT_W-1:0]  in_flight_reg, in_flight_next;
    logic [CNT_W-1:0]  discard_reg, discard_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [CNT_W:0] occupancy;
    logic           credit_ok;
    logic           issue;
    logic           resp_ok;
    logic           push;
    logic           pop;

    // Buffered plus outstanding entries never exceed DEPTH, so a push always has room.
    assign occupancy = {1'b0, count_reg} + {1'b0, in_flight_reg};
    assign credit_ok = occupancy < CREDIT;

    assign mem.mem_req  = rst & ~flush_i & credit_ok;
    assign mem.mem_addr = fetch_pc_reg;

    assign inst_valid_o = rst & ~flush_i & (count_reg != '0);
    assign inst_o       = data_mem[rd_ptr_reg];
    assign inst_addr_o  = addr_mem[rd_ptr_reg];

    assign issue   = mem.mem_req & mem.mem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign resp_ok = mem.mem_rvalid & (in_flight_reg != '0);
    assign push    = resp_ok & ~flush_i & (discard_reg == '0);
    assign pop     = inst_valid_o & inst_ready_i;

    always_comb begin
        fetch_pc_next  = fetch_pc_reg;
        resp_pc_next   = resp_pc_reg;
        in_flight_next = in_flight_reg + CNT_W'(issue) - CNT_W'(resp_ok);
        discard_next   = discard_reg;
        count_next     = count_reg + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_next    = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next    = rd_ptr_reg + PTR_W'(pop);

        if (issue) begin
            fetch_pc_next = fetch_pc_reg + PC_INC;
        end
        if (push) begin
            resp_pc_next = resp_pc_reg + PC_INC;
        end
        if (resp_ok && (discard_reg != '0)) begin
            discard_next = discard_reg - 1'b1;
        end

        // Every request still outstanding at a redirect belongs to the old stream.
        if (flush_i) begin
            fetch_pc_next = flush_addr_i;
            resp_pc_next  = flush_addr_i;
            discard_next  = in_flight_reg - CNT_W'(resp_ok);
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg  <= RESET_PC;
            resp_pc_reg   <= RESET_PC;
            in_flight_reg <= '0;
            discard_reg   <= '0;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            fetch_pc_reg  <= fetch_pc_next;
            resp_pc_reg   <= resp_pc_next;
            in_flight_reg <= in_flight_next;
            discard_reg   <= discard_next;
            count_reg     <= count_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= resp_pc_reg;
            data_mem[wr_ptr_reg] <= mem.mem_rdata;
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Bench for ifetch_prefetch_buf: in-order memory with configurable latency, an epoch-tagged
// stream model checked every cycle, and directed scenarios with literal expectations.
module tb_ifetch_prefetch_buf;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RP    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = '0;
    logic        inst_ready_i = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    ifetch_prefetch_buf_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    ifetch_prefetch_buf #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush_i),
        .flush_addr_i(flush_addr_i),
        .inst_ready_i(inst_ready_i),
        .inst_valid_o(inst_valid_o),
        .inst_o(inst_o),
        .inst_addr_o(inst_addr_o),
        .mem(mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;    // address the DUT actually requested
        logic [31:0] exp_pc;  // address the model expected it to request
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    req_t        mem_q[$];
    ent_t        buf_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] exp_stream_pc;
    int          m_epoch;
    int          cyc;
    int          errors = 0;
    int          checks = 0;

    logic        gnt_en = 1'b0;
    int          lat_min = 1;
    int          lat_max = 1;

    logic [31:0] pops_q[$];
    logic [31:0] grants_q[$];
    int          grant_cyc_q[$];
    int          first_valid_cyc;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic clear_log();
        pops_q.delete();
        grants_q.delete();
        grant_cyc_q.delete();
        first_valid_cyc = -1;
    endtask

    // One clock cycle: drive memory, compare outputs against the model, advance the model.
    task automatic step();
        req_t r;
        ent_t e;
        bit   rv, exp_req, exp_valid;
        mem_if.mem_gnt    = gnt_en;
        rv                = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        mem_if.mem_rvalid = rv;
        mem_if.mem_rdata  = rv ? mem_data(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        exp_req   = !flush_i && ((buf_q.size() + mem_q.size()) < DEPTH);
        exp_valid = !flush_i && (buf_q.size() != 0);
        chk("mem_req", 32'(mem_if.mem_req), 32'(exp_req));
        if (exp_req) chk("mem_addr", mem_if.mem_addr, m_fetch_pc);
        chk("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            chk("inst_addr", inst_addr_o, buf_q[0].addr);
            chk("inst_data", inst_o, buf_q[0].data);
        end
        if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_valid_o && inst_ready_i) begin
            pops_q.push_back(inst_addr_o);
            chk("stream_pc", inst_addr_o, exp_stream_pc);
            exp_stream_pc += 32'd4;
        end
        $display("cyc=%0d flush=%0b req=%0b gnt=%0b addr=%h rv=%0b valid=%0b rdy=%0b pc=%h inst=%h",
                 cyc, flush_i, mem_if.mem_req, mem_if.mem_gnt, mem_if.mem_addr, rv,
                 inst_valid_o, inst_ready_i, inst_addr_o, inst_o);

        if (exp_valid && inst_ready_i) void'(buf_q.pop_front());
        if (rv) begin
            r = mem_q.pop_front();
            if (!flush_i && r.epoch == m_epoch) begin
                e.addr = r.exp_pc;
                e.data = mem_data(r.exp_pc);
                buf_q.push_back(e);
            end
        end
        if (mem_if.mem_req && mem_if.mem_gnt) begin
            r.addr   = mem_if.mem_addr;
            r.exp_pc = m_fetch_pc;
            r.epoch  = m_epoch;
            r.due    = cyc + int'($urandom_range(lat_max, lat_min));
            mem_q.push_back(r);
            grants_q.push_back(mem_if.mem_addr);
            grant_cyc_q.push_back(cyc);
            m_fetch_pc += 32'd4;
        end
        if (flush_i) begin
            buf_q.delete();
            m_fetch_pc    = flush_addr_i;
            exp_stream_pc = flush_addr_i;
            m_epoch++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asserts reset away from the clock edge, checks the outputs fall at once, then releases.
    task automatic do_reset();
        #2;
        rst               = 1'b0;
        flush_i           = 1'b0;
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        mem_q.delete();
        buf_q.delete();
        m_fetch_pc    = RP;
        exp_stream_pc = RP;
        m_epoch       = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        clear_log();
    endtask

    initial begin
        int bad;
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;
        cyc               = 0;
        clear_log();

        // Streaming from reset with single-cycle memory.
        do_reset();
        gnt_en = 1'b1; inst_ready_i = 1'b1; lat_min = 1; lat_max = 1;
        repeat (10) step();
        chk("t1_first_grant", grants_q[0], RP);
        chk("t1_first_grant_cyc", 32'(grant_cyc_q[0]), 32'd0);
        chk("t1_first_valid_cyc", 32'(first_valid_cyc), 32'd2);
        chk("t1_pop0", pops_q[0], RP);
        chk("t1_pop1", pops_q[1], RP + 32'h4);
        chk("t1_pop2", pops_q[2], RP + 32'h8);
        chk("t1_npops", 32'(pops_q.size()), 32'd8);

        // Back-pressure: credit stops issue at DEPTH, then drains in order.
        do_reset();
        gnt_en = 1'b1; inst_ready_i = 1'b0;
        repeat (8) step();
        chk("t2_ngrants", 32'(grants_q.size()), 32'd4);
        chk("t2_req_stalled", 32'(mem_if.mem_req), 32'd0);
        chk("t2_valid_full", 32'(inst_valid_o), 32'd1);
        inst_ready_i = 1'b1;
        repeat (8) step();
        chk("t2_pop0", pops_q[0], RP);
        chk("t2_pop1", pops_q[1], RP + 32'h4);
        chk("t2_pop2", pops_q[2], RP + 32'h8);
        chk("t2_pop3", pops_q[3], RP + 32'hC);
        chk("t2_resume", grants_q[4], RP + 32'h10);

        // Flush with three slow responses outstanding.
        do_reset();
        gnt_en = 1'b1; inst_ready_i = 1'b1; lat_min = 3; lat_max = 3;
        repeat (3) step();
        clear_log();
        flush_i = 1'b1; flush_addr_i = 32'h0000_0100;
        step();
        flush_i = 1'b0;
        repeat (20) step();
        chk("t3_npops", 32'(pops_q.size() >= 3), 32'd1);
        chk("t3_pop0", pops_q[0], 32'h0000_0100);
        chk("t3_grant0", grants_q[0], 32'h0000_0100);
        chk("t3_first_valid_cyc", 32'(first_valid_cyc), 32'd8);
        bad = 0;
        foreach (pops_q[i]) if (pops_q[i] >= RP) bad++;
        chk("t3_stale", 32'(bad), 32'd0);

        // Back-to-back flushes, the first one coinciding with a response.
        do_reset();
        gnt_en = 1'b1; inst_ready_i = 1'b1; lat_min = 1; lat_max = 1;
        repeat (6) step();
        clear_log();
        flush_i = 1'b1; flush_addr_i = 32'h0000_0200;
        step();
        flush_addr_i = 32'h0000_0300;
        step();
        flush_i = 1'b0;
        repeat (10) step();
        chk("t4_grant0", grants_q[0], 32'h0000_0300);
        chk("t4_grant0_cyc", 32'(grant_cyc_q[0]), 32'd8);
        chk("t4_first_valid_cyc", 32'(first_valid_cyc), 32'd10);
        chk("t4_pop0", pops_q[0], 32'h0000_0300);
        chk("t4_pop1", pops_q[1], 32'h0000_0304);
        bad = 0;
        foreach (pops_q[i]) if (pops_q[i][31:8] != 24'h3) bad++;
        chk("t4_stale", 32'(bad), 32'd0);

        // Random grant, latency, ready and flushes; starts with an address-wrap redirect.
        do_reset();
        lat_min = 1; lat_max = 4; gnt_en = 1'b1; inst_ready_i = 1'b1;
        flush_i = 1'b1; flush_addr_i = 32'hFFFF_FFF8;
        step();
        flush_i = 1'b0;
        repeat (12) step();
        chk("t5_wrap", 32'(pops_q.size() >= 3 && pops_q[2] == 32'h0000_0000), 32'd1);
        for (int i = 0; i < 3000; i++) begin
            gnt_en       = ($urandom_range(0, 3) != 0);
            inst_ready_i = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 31) == 0);
            flush_addr_i = $urandom & 32'h000F_FFFC;
            step();
        end
        flush_i = 1'b0;
        chk("t5_progress", 32'(pops_q.size() > 500), 32'd1);

        // Reset mid-burst with two buffered and two outstanding.
        do_reset();
        gnt_en = 1'b1; inst_ready_i = 1'b0; lat_min = 6; lat_max = 6;
        repeat (8) step();
        chk("t6_valid_before", 32'(inst_valid_o), 32'd1);
        chk("t6_req_before", 32'(mem_if.mem_req), 32'd0);
        do_reset();
        inst_ready_i = 1'b1; lat_min = 1; lat_max = 1;
        repeat (4) step();
        chk("t6_restart_grant", grants_q[0], RP);
        chk("t6_restart_pop", pops_q[0], RP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
